// File: rtl/minmax_tracker.sv
// Running min/max tracker over a window of unsigned samples.
// Keeps registered extremes, a saturating sample count and one-cycle
// pulses that flag when the last accepted sample set a new extreme.
module minmax_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             clear,
  output logic [N-1:0]     min_out,
  output logic [N-1:0]     max_out,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  output logic             new_min,
  output logic             new_max,
  output logic             count_sat
);

  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     min_q, min_d;
  logic [N-1:0]     max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nmin_q, nmin_d;
  logic             nmax_q, nmax_d;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // State and datapath registers; reset returns every output to zero at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      nmin_q  <= 1'b0;
      nmax_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      nmin_q  <= nmin_d;
      nmax_q  <= nmax_d;
    end
  end

  // Next-state: a sample on a fresh window (EMPTY or clear) seeds both
  // extremes; clear alone empties the window; otherwise extend the window.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    nmin_d  = 1'b0;
    nmax_d  = 1'b0;
    if (in_valid && (clear || state_q == EMPTY)) begin
      state_d = TRACK;
      min_d   = in_data;
      max_d   = in_data;
      cnt_d   = CNT_ONE;
      nmin_d  = 1'b1;
      nmax_d  = 1'b1;
    end else if (clear) begin
      state_d = EMPTY;
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      // Both tests are independent so an inconsistent min>max still updates both.
      if (in_data < min_q) begin
        min_d  = in_data;
        nmin_d = 1'b1;
      end
      if (in_data > max_q) begin
        max_d  = in_data;
        nmax_d = 1'b1;
      end
      cnt_d = sat_inc(cnt_q);
    end
  end

  assign min_out   = min_q;
  assign max_out   = max_q;
  assign count     = cnt_q;
  assign out_valid = (state_q == TRACK);
  assign new_min   = nmin_q;
  assign new_max   = nmax_q;
  assign count_sat = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: a wide-count instance and a
// 3-bit-count instance share the same stimulus.
module tb_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear;

  logic [7:0]  min_a, max_a, min_b, max_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        ov_a, nmin_a, nmax_a, sat_a;
  logic        ov_b, nmin_b, nmax_b, sat_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int mn; int mx; int c16; int c3; bit ov; bit pmin; bit pmax;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  bit trk;
  int mn, mx, c16, c3;
  bit pmin, pmax;

  always #5 clk = ~clk;

  minmax_tracker #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .min_out(min_a), .max_out(max_a), .count(cnt_a), .out_valid(ov_a),
    .new_min(nmin_a), .new_max(nmax_a), .count_sat(sat_a));

  minmax_tracker #(.N(8), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .min_out(min_b), .max_out(max_b), .count(cnt_b), .out_valid(ov_b),
    .new_min(nmin_b), .new_max(nmax_b), .count_sat(sat_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    trk = 0; mn = 0; mx = 0; c16 = 0; c3 = 0; pmin = 0; pmax = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    pmin = 0; pmax = 0;
    if (v && (c || !trk)) begin
      trk = 1; mn = d; mx = d; c16 = 1; c3 = 1; pmin = 1; pmax = 1;
    end else if (c) begin
      trk = 0; mn = 0; mx = 0; c16 = 0; c3 = 0;
    end else if (v) begin
      if (d < mn) begin mn = d; pmin = 1; end
      if (d > mx) begin mx = d; pmax = 1; end
      if (c16 < 65535) c16++;
      if (c3 < 7) c3++;
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("min", min_a, e.mn);
    chk("max", max_a, e.mx);
    chk("count", cnt_a, e.c16);
    chk("out_valid", ov_a, e.ov);
    chk("new_min", nmin_a, e.pmin);
    chk("new_max", nmax_a, e.pmax);
    chk("count_sat", sat_a, (e.c16 == 65535));
    chk("s_min", min_b, e.mn);
    chk("s_max", max_b, e.mx);
    chk("s_count", cnt_b, e.c3);
    chk("s_count_sat", sat_b, (e.c3 == 7));
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cyc(input bit v, input int d, input bit c);
    exp_t e;
    in_valid = v; in_data = 8'(d); clear = c;
    model_step(v, d, c);
    e.mn = mn; e.mx = mx; e.c16 = c16; e.c3 = c3; e.ov = trk; e.pmin = pmin; e.pmax = pmax;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      check_all(sb.pop_front());
    end
    in_valid = 0; clear = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_min"}, min_a, 0);
    chk({tag, "_max"}, max_a, 0);
    chk({tag, "_count"}, cnt_a, 0);
    chk({tag, "_ov"}, ov_a, 0);
    chk({tag, "_nmin"}, nmin_a, 0);
    chk({tag, "_nmax"}, nmax_a, 0);
    chk({tag, "_sat"}, sat_a, 0);
  endtask

  initial begin
    int bmin[6] = '{50, 20, 20, 20, 20, 20};
    int bmax[6] = '{50, 50, 90, 90, 90, 90};
    bit bpm[6]  = '{1, 1, 0, 0, 0, 0};
    bit bpx[6]  = '{1, 0, 1, 0, 0, 0};
    int bsmp[6] = '{50, 20, 90, 20, 90, 60};

    rst = 1; in_valid = 0; in_data = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;

    // Basic tracking with spec-listed constants alongside the model
    for (int i = 0; i < 6; i++) begin
      cyc(1, bsmp[i], 0);
      chk("basic_min", min_a, bmin[i]);
      chk("basic_max", max_a, bmax[i]);
      chk("basic_pmin", nmin_a, bpm[i]);
      chk("basic_pmax", nmax_a, bpx[i]);
    end
    chk("basic_count", cnt_a, 6);

    // Gaps
    cyc(0, 0, 1);
    cyc(1, 10, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 77, 0);
      chk("gap_min_hold", min_a, 10);
      chk("gap_pulse", nmin_a | nmax_a, 0);
    end
    cyc(1, 5, 0);
    chk("gap_min", min_a, 5);
    chk("gap_count", cnt_a, 2);

    // Clear precedence
    cyc(0, 0, 1);
    cyc(1, 3, 0);
    cyc(1, 200, 0);
    for (int i = 0; i < 5; i++) cyc(1, 50, 0);
    chk("pre_count", cnt_a, 7);
    cyc(1, 100, 1);
    chk("clr_min", min_a, 100);
    chk("clr_max", max_a, 100);
    chk("clr_count", cnt_a, 1);
    chk("clr_pulses", {nmin_a, nmax_a}, 2'b11);
    cyc(0, 0, 1);
    check_zero("clear_alone");
    cyc(0, 0, 1);
    check_zero("clear_empty");

    // Extremes
    cyc(1, 255, 0);
    chk("ext_pmax1", nmax_a, 1);
    cyc(1, 0, 0);
    chk("ext_pmax2", nmax_a, 0);
    chk("ext_pmin2", nmin_a, 1);
    cyc(1, 255, 0);
    chk("ext_min", min_a, 0);
    chk("ext_max", max_a, 255);
    chk("ext_pulse3", {nmin_a, nmax_a}, 2'b00);

    // Saturation on the 3-bit counter instance
    cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 100 - 10 * i, 0);
      if (i >= 6) chk("sat_flag", sat_b, 1);
      else chk("sat_flag_low", sat_b, 0);
    end
    chk("sat_count", cnt_b, 7);
    chk("sat_min", min_b, 20);
    chk("sat_pmin", nmin_b, 1);
    chk("wide_count", cnt_a, 9);

    // Asynchronous reset mid-window
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 40 + i, 0);
    chk("pre_rst_count", cnt_a, 5);
    #2;
    rst = 1;
    #1;
    check_zero("async_rst");
    chk("async_rst_s_count", cnt_b, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 0);
    cyc(1, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Sequential stage downstream of the N-bit magnitude comparator.
- Consumes a stream of unsigned N-bit samples and keeps the running minimum and maximum of the current window.
- Keeps a saturating sample count for the window.
- Emits one-cycle pulses when a sample sets a new extreme.
- Feeds status and threshold logic that needs registered extremes rather than per-sample compare flags.

Parameters:
- N, 8, sample width in bits; unsigned.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is a valid sample this cycle.
- in_data  input  N  unsigned sample.
- clear  input  1  synchronous window restart.
- min_out  output  N  registered running minimum.
- max_out  output  N  registered running maximum.
- count  output  CNT_W  samples accepted in the current window, saturating.
- out_valid  output  1  high when the window holds at least one sample.
- new_min  output  1  one-cycle pulse: last accepted sample was strictly below the previous min.
- new_max  output  1  one-cycle pulse: last accepted sample was strictly above the previous max.
- count_sat  output  1  count has reached 2^CNT_W-1.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: min_out=0, max_out=0, count=0, out_valid=0, new_min=0, new_max=0, count_sat=0. State = EMPTY.
- Reset asserted mid-window: all outputs return to reset values immediately, with no clock edge needed.
- States:
  - EMPTY: no samples in the window.
  - TRACK: at least one sample accepted.
- EMPTY behaviour:
  - in_valid=1: min_out=max_out=in_data, count=1, out_valid=1, new_min=1, new_max=1, go to TRACK.
  - in_valid=0: hold all outputs; pulses low.
- TRACK behaviour on in_valid=1:
  - in_data < min_out: update min_out, pulse new_min.
  - in_data > max_out: update max_out, pulse new_max.
  - Both tests are done in the same cycle. Both can be true only when min_out > max_out, which cannot happen; if it did, both updates apply.
  - in_data equal to min_out or max_out: no update, no pulse.
  - count increments by 1 and saturates at 2^CNT_W-1. It never wraps to 0.
- TRACK behaviour on in_valid=0: hold all outputs; pulses low.
- All comparisons are unsigned, N-bit.
- Latency: outputs reflect a sample on the clock edge that accepts it (1 cycle after presentation).
- new_min and new_max are high for exactly the one cycle following the accepting edge. They are never high when in_valid was low on the prior edge.
- count_sat = (count == all ones). It is combinational from the count register.
- clear=1, in_valid=0: go to EMPTY. min_out, max_out and count = 0; out_valid=0; pulses low.
- clear=1, in_valid=1, same cycle: clear wins over the old window, and the sample becomes the first sample of the new window.
  - Result: min_out=max_out=in_data, count=1, out_valid=1, new_min=new_max=1, state TRACK.
- clear while already EMPTY: no effect beyond the rules above.
- Values 0 and 2^N-1 are legal samples with no special handling.
- No backpressure: every in_valid=1 cycle is accepted.

Test Plan:
- Reset value check:
  - Stimulus: assert rst asynchronously mid-cycle with count=5.
  - Required: all outputs 0 before the next clk edge; state EMPTY.
- Basic tracking, N=8:
  - Stimulus: samples 50, 20, 90, 20, 90, 60 on consecutive cycles.
  - Required min_out: 50, 20, 20, 20, 20, 20.
  - Required max_out: 50, 50, 90, 90, 90, 90.
  - Required new_min pulses: cycles 1, 2 only.
  - Required new_max pulses: cycles 1, 3 only.
  - Required count: 6.
- Gaps:
  - Stimulus: samples 10, idle 3 cycles, 5.
  - Required: outputs hold during idle with pulses low; then min_out=5, count=2.
- Clear precedence:
  - Stimulus: after min=3/max=200/count=7, pulse clear with in_valid=1, in_data=100.
  - Required: min=max=100, count=1, new_min=new_max=1.
  - Stimulus: then clear alone.
  - Required: out_valid=0, min/max/count=0.
- Extremes:
  - Stimulus: samples 255, 0, 255.
  - Required: min=0, max=255; new_max only on the first sample; no pulse on the third.
- Saturation, CNT_W=3:
  - Stimulus: 9 valid samples.
  - Required: count reaches 7 and stays 7; count_sat=1 from the 7th sample onward; min/max still update.
